move_controller: RTL and testbench

//  Sequences one player move per request on the tile map. It accepts a one-hot

---
 rtl/move_controller_pkg.sv | 31 +++
 rtl/move_controller_bound.sv | 38 +++
 rtl/move_controller.sv | 142 ++++++++++++++
 tb/tb_move_controller.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/move_controller_pkg.sv
// Shared game constants for the tile map, direction encoding and the move sequencer states.
package move_controller_pkg;

  localparam int MAP_WIDTH_DEF  = 16;
  localparam int MAP_HEIGHT_DEF = 12;

  localparam int POS_W  = 4;
  localparam int ADDR_W = 8;
  localparam int TILE_W = 4;
  localparam int DIR_W  = 4;

  localparam int DIR_LEFT  = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_UP    = 2;
  localparam int DIR_RIGHT = 3;

  localparam logic [TILE_W-1:0] TILE_FLOOR = 4'd0;
  localparam logic [TILE_W-1:0] TILE_WALL  = 4'd1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CHECK    = 2'd1,
    ST_TILE     = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

  function automatic logic is_onehot(input logic [DIR_W-1:0] v);
    return (v != '0) && ((v & (v - DIR_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/move_controller_bound.sv
// Bound check for one step: decides whether the direction is a legal single step
// from the current position and produces the target coordinate when it is.
module check_bound
  import move_controller_pkg::*;
#(
  parameter int MAP_WIDTH  = MAP_WIDTH_DEF,
  parameter int MAP_HEIGHT = MAP_HEIGHT_DEF
) (
  input  logic [POS_W-1:0] i_pos_x,
  input  logic [POS_W-1:0] i_pos_y,
  input  logic [DIR_W-1:0] i_move,
  output logic             o_ok,
  output logic [POS_W-1:0] o_tgt_x,
  output logic [POS_W-1:0] o_tgt_y
);

  logic [DIR_W-1:0] w_allow;

  assign w_allow[DIR_LEFT]  = (i_pos_x != '0);
  assign w_allow[DIR_RIGHT] = (i_pos_x < POS_W'(MAP_WIDTH - 1));
  assign w_allow[DIR_UP]    = (i_pos_y != '0);
  assign w_allow[DIR_DOWN]  = (i_pos_y < POS_W'(MAP_HEIGHT - 1));

  assign o_ok = is_onehot(i_move) && ((w_allow & i_move) != '0);

  // Target only moves when the step is legal, so the 4-bit arithmetic never wraps.
  always_comb begin
    o_tgt_x = i_pos_x;
    o_tgt_y = i_pos_y;
    if (o_ok) begin
      if (i_move[DIR_LEFT])       o_tgt_x = i_pos_x - POS_W'(1);
      else if (i_move[DIR_RIGHT]) o_tgt_x = i_pos_x + POS_W'(1);
      else if (i_move[DIR_UP])    o_tgt_y = i_pos_y - POS_W'(1);
      else                        o_tgt_y = i_pos_y + POS_W'(1);
    end
  end

endmodule

// File: rtl/move_controller.sv
// Player move sequencer: accept a direction, bound-check it, read the target tile,
// commit or reject the step with a one-cycle pulse, then hold off for a cooldown.
module move_controller
  import move_controller_pkg::*;
#(
  parameter int                MAP_WIDTH       = MAP_WIDTH_DEF,
  parameter int                MAP_HEIGHT      = MAP_HEIGHT_DEF,
  parameter int                START_X         = 0,
  parameter int                START_Y         = 0,
  parameter int                COOLDOWN_CYCLES = 4,
  parameter logic [TILE_W-1:0] WALL_TILE       = TILE_WALL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIR_W-1:0]  move,
  input  logic              move_valid,
  output logic              move_ready,
  output logic              tile_rd_en,
  output logic [ADDR_W-1:0] tile_addr,
  input  logic [TILE_W-1:0] tile_data,
  output logic [POS_W-1:0]  pos_x,
  output logic [POS_W-1:0]  pos_y,
  output logic              moved,
  output logic              blocked
);

  localparam int CNT_W = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (COOLDOWN_CYCLES > 0) ? CNT_W'(COOLDOWN_CYCLES - 1) : '0;

  state_t            r_state;
  state_t            w_next;
  logic [DIR_W-1:0]  r_move;
  logic              r_ok;
  logic [POS_W-1:0]  r_tgt_x;
  logic [POS_W-1:0]  r_tgt_y;
  logic [ADDR_W-1:0] r_addr;
  logic [POS_W-1:0]  r_pos_x;
  logic [POS_W-1:0]  r_pos_y;
  logic              r_moved;
  logic              r_blocked;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_ok;
  logic [POS_W-1:0]  w_tgt_x;
  logic [POS_W-1:0]  w_tgt_y;
  logic [ADDR_W-1:0] w_addr;
  logic              w_result;

  check_bound #(
    .MAP_WIDTH  (MAP_WIDTH),
    .MAP_HEIGHT (MAP_HEIGHT)
  ) u_bound (
    .i_pos_x (r_pos_x),
    .i_pos_y (r_pos_y),
    .i_move  (r_move),
    .o_ok    (w_ok),
    .o_tgt_x (w_tgt_x),
    .o_tgt_y (w_tgt_y)
  );

  assign w_addr   = ADDR_W'(w_tgt_y) * ADDR_W'(MAP_WIDTH) + ADDR_W'(w_tgt_x);
  assign w_result = r_ok && (tile_data != WALL_TILE);

  assign pos_x   = r_pos_x;
  assign pos_y   = r_pos_y;
  assign moved   = r_moved;
  assign blocked = r_blocked;

  always_comb begin
    w_next     = r_state;
    move_ready = 1'b0;
    tile_rd_en = 1'b0;
    tile_addr  = r_addr;
    unique case (r_state)
      ST_IDLE: begin
        move_ready = 1'b1;
        if (move_valid) w_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_ok) begin
          tile_rd_en = 1'b1;
          tile_addr  = w_addr;
        end
        w_next = ST_TILE;
      end
      ST_TILE: begin
        w_next = (COOLDOWN_CYCLES > 0) ? ST_COOLDOWN : ST_IDLE;
      end
      ST_COOLDOWN: begin
        if (r_cnt == '0) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // The RAM answers one cycle after the read strobe, so the wall test happens in TILE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_move    <= '0;
      r_ok      <= 1'b0;
      r_tgt_x   <= POS_W'(START_X);
      r_tgt_y   <= POS_W'(START_Y);
      r_addr    <= '0;
      r_pos_x   <= POS_W'(START_X);
      r_pos_y   <= POS_W'(START_Y);
      r_moved   <= 1'b0;
      r_blocked <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_next;
      r_moved   <= 1'b0;
      r_blocked <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (move_valid) r_move <= move;
        end
        ST_CHECK: begin
          r_ok    <= w_ok;
          r_tgt_x <= w_tgt_x;
          r_tgt_y <= w_tgt_y;
          if (w_ok) r_addr <= w_addr;
        end
        ST_TILE: begin
          if (w_result) begin
            r_pos_x <= r_tgt_x;
            r_pos_y <= r_tgt_y;
          end
          r_moved   <= w_result;
          r_blocked <= ~w_result;
          r_cnt     <= CNT_LOAD;
        end
        ST_COOLDOWN: begin
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: a map RAM model, a position/step reference model and
// directed plus randomized move scenarios on two configurations (cooldown 4 and 0).
module tb_move_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] move;
  logic       move_valid;
  logic       move_ready;
  logic       tile_rd_en;
  logic [7:0] tile_addr;
  logic [3:0] tile_data;
  logic [3:0] pos_x, pos_y;
  logic       moved, blocked;

  logic [3:0] move2;
  logic       move_valid2;
  logic       move_ready2;
  logic       tile_rd_en2;
  logic [7:0] tile_addr2;
  logic [3:0] tile_data2;
  logic [3:0] pos_x2, pos_y2;
  logic       moved2, blocked2;

  logic [3:0] mem [256];
  int         rd_cnt = 0;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         mx, my;

  always #5 clk = ~clk;

  move_controller #(
    .MAP_WIDTH(16), .MAP_HEIGHT(12), .START_X(5), .START_Y(5),
    .COOLDOWN_CYCLES(4), .WALL_TILE(4'd1)
  ) dut (
    .clk(clk), .rst(rst), .move(move), .move_valid(move_valid),
    .move_ready(move_ready), .tile_rd_en(tile_rd_en), .tile_addr(tile_addr),
    .tile_data(tile_data), .pos_x(pos_x), .pos_y(pos_y),
    .moved(moved), .blocked(blocked)
  );

  move_controller #(
    .MAP_WIDTH(16), .MAP_HEIGHT(12), .START_X(5), .START_Y(5),
    .COOLDOWN_CYCLES(0), .WALL_TILE(4'd1)
  ) dut0 (
    .clk(clk), .rst(rst), .move(move2), .move_valid(move_valid2),
    .move_ready(move_ready2), .tile_rd_en(tile_rd_en2), .tile_addr(tile_addr2),
    .tile_data(tile_data2), .pos_x(pos_x2), .pos_y(pos_y2),
    .moved(moved2), .blocked(blocked2)
  );

  always @(posedge clk) begin
    tile_data <= mem[tile_addr];
    cyc <= cyc + 1;
    if (tile_rd_en === 1'b1) rd_cnt <= rd_cnt + 1;
  end

  assign tile_data2 = 4'd0;

  // One full transaction from IDLE, checked cycle by cycle against the model.
  task automatic step(input logic [3:0] dir);
    int tx, ty, eaddr, rd0, w;
    bit ok, res;
    tx = mx; ty = my;
    ok = ($countones(dir) == 1);
    if (ok) begin
      if (dir[0])      tx = mx - 1;
      else if (dir[3]) tx = mx + 1;
      else if (dir[2]) ty = my - 1;
      else             ty = my + 1;
      ok = (tx >= 0) && (tx < 16) && (ty >= 0) && (ty < 12);
    end
    eaddr = ok ? (ty * 16 + tx) : 0;
    res = ok && (mem[eaddr] != 4'd1);

    w = 0;
    while (move_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    n_tests++;
    if (move_ready !== 1'b1) begin
      n_fail++; $display("FAIL step_ready got=%b want=1", move_ready);
    end
    move = dir; move_valid = 1'b1; rd0 = rd_cnt;
    @(negedge clk);
    move_valid = 1'b0; move = 4'($urandom);
    n_tests++;
    if (tile_rd_en !== ok || move_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL check_cycle dir=%b rd_en=%b ready=%b want rd_en=%b ready=0", dir, tile_rd_en, move_ready, ok);
    end
    if (ok) begin
      n_tests++;
      if (tile_addr !== 8'(eaddr)) begin
        n_fail++; $display("FAIL tile_addr dir=%b got=%0d want=%0d", dir, tile_addr, eaddr);
      end
    end
    @(negedge clk);
    n_tests++;
    if (tile_rd_en !== 1'b0 || moved !== 1'b0 || blocked !== 1'b0 ||
        pos_x !== 4'(mx) || pos_y !== 4'(my)) begin
      n_fail++;
      $display("FAIL tile_cycle rd_en=%b moved=%b blocked=%b pos=(%0d,%0d) want 0,0,0 (%0d,%0d)",
               tile_rd_en, moved, blocked, pos_x, pos_y, mx, my);
    end
    @(negedge clk);
    if (res) begin mx = tx; my = ty; end
    n_tests++;
    if (moved !== res || blocked !== !res || pos_x !== 4'(mx) || pos_y !== 4'(my) ||
        (rd_cnt - rd0) != int'(ok)) begin
      n_fail++;
      $display("FAIL result dir=%b moved=%b blocked=%b pos=(%0d,%0d) reads=%0d want moved=%b pos=(%0d,%0d) reads=%0d",
               dir, moved, blocked, pos_x, pos_y, rd_cnt - rd0, res, mx, my, int'(ok));
    end
    @(negedge clk);
    n_tests++;
    if (moved !== 1'b0 || blocked !== 1'b0) begin
      n_fail++; $display("FAIL pulse_width moved=%b blocked=%b want 0,0", moved, blocked);
    end
  endtask

  task automatic goto(input int x, input int y);
    while (mx > x) step(4'b0001);
    while (mx < x) step(4'b1000);
    while (my > y) step(4'b0100);
    while (my < y) step(4'b0010);
  endtask

  task automatic test_reset;
    rst = 1'b1; move = '0; move_valid = 1'b0; move2 = '0; move_valid2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; mx = 5; my = 5;
    @(negedge clk);
    n_tests++;
    if (move_ready !== 1'b1 || pos_x !== 4'd5 || pos_y !== 4'd5 || moved !== 1'b0 ||
        blocked !== 1'b0 || tile_rd_en !== 1'b0 || tile_addr !== 8'd0) begin
      n_fail++;
      $display("FAIL reset ready=%b pos=(%0d,%0d) moved=%b blocked=%b rd_en=%b addr=%0d want 1 (5,5) 0 0 0 0",
               move_ready, pos_x, pos_y, moved, blocked, tile_rd_en, tile_addr);
    end
    n_tests++;
    if (move_ready2 !== 1'b1 || pos_x2 !== 4'd5 || pos_y2 !== 4'd5 || moved2 !== 1'b0 || blocked2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cd0 ready=%b pos=(%0d,%0d) want 1 (5,5)", move_ready2, pos_x2, pos_y2);
    end
  endtask

  task automatic test_floor_left;
    step(4'b0001);
    n_tests++;
    if (mx != 4 || pos_x !== 4'd4 || pos_y !== 4'd5) begin
      n_fail++; $display("FAIL floor_left pos=(%0d,%0d) want (4,5)", pos_x, pos_y);
    end
  endtask

  task automatic test_bounds;
    goto(0, 3);  step(4'b0001);
    goto(15, 3); step(4'b1000);
    goto(15, 11); step(4'b0010);
    goto(0, 0);  step(4'b0100);
  endtask

  task automatic test_wall;
    goto(2, 2);
    mem[2 * 16 + 3] = 4'd1;
    step(4'b1000);
    n_tests++;
    if (pos_x !== 4'd2 || pos_y !== 4'd2) begin
      n_fail++; $display("FAIL wall pos=(%0d,%0d) want (2,2)", pos_x, pos_y);
    end
    mem[2 * 16 + 3] = 4'd0;
  endtask

  task automatic test_invalid;
    step(4'b0101);
    step(4'b0000);
    step(4'b1111);
    step(4'b1010);
  endtask

  task automatic test_random;
    logic [3:0] d;
    for (int i = 0; i < 192; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? 4'd1 : 4'($urandom_range(0, 15) & 4'hE);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0) d = 4'b0001 << $urandom_range(0, 3);
      else d = 4'($urandom);
      step(d);
    end
    for (int i = 0; i < 256; i++) mem[i] = 4'd0;
  endtask

  task automatic test_back_to_back;
    int acc[$];
    int w, rd0;
    rd0 = rd_cnt;
    move = 4'b0000; move_valid = 1'b1; w = 0;
    while (acc.size() < 3 && w < 40) begin
      if (move_ready === 1'b1) acc.push_back(cyc);
      @(negedge clk); w++;
    end
    move_valid = 1'b0;
    n_tests++;
    if (acc.size() != 3) begin
      n_fail++; $display("FAIL b2b_cd4_count got=%0d want=3", acc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_tests++;
        if (acc[i] - acc[i-1] != 7) begin
          n_fail++; $display("FAIL b2b_cd4_gap got=%0d want=7", acc[i] - acc[i-1]);
        end
      end
    end
    w = 0;
    while (move_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    n_tests++;
    if (rd_cnt != rd0 || pos_x !== 4'(mx) || pos_y !== 4'(my)) begin
      n_fail++; $display("FAIL b2b_cd4_side reads=%0d pos=(%0d,%0d) want 0 (%0d,%0d)", rd_cnt - rd0, pos_x, pos_y, mx, my);
    end

    acc.delete();
    move2 = 4'b0000; move_valid2 = 1'b1; w = 0;
    while (acc.size() < 3 && w < 40) begin
      if (move_ready2 === 1'b1) acc.push_back(cyc);
      @(negedge clk); w++;
    end
    move_valid2 = 1'b0;
    n_tests++;
    if (acc.size() != 3) begin
      n_fail++; $display("FAIL b2b_cd0_count got=%0d want=3", acc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_tests++;
        if (acc[i] - acc[i-1] != 3) begin
          n_fail++; $display("FAIL b2b_cd0_gap got=%0d want=3", acc[i] - acc[i-1]);
        end
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int w;
    goto(6, 6);
    w = 0;
    while (move_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    move = 4'b0001; move_valid = 1'b1;
    @(negedge clk);
    move_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mx = 5; my = 5;
    n_tests++;
    if (moved !== 1'b0 || blocked !== 1'b0 || pos_x !== 4'd5 || pos_y !== 4'd5) begin
      n_fail++;
      $display("FAIL mid_reset moved=%b blocked=%b pos=(%0d,%0d) want 0 0 (5,5)", moved, blocked, pos_x, pos_y);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (move_ready !== 1'b1 || moved !== 1'b0 || tile_addr !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_reset_ready ready=%b moved=%b addr=%0d want 1 0 0", move_ready, moved, tile_addr);
    end
    step(4'b0001);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 4'd0;
    rst = 1'b1;
    move = '0; move_valid = 1'b0; move2 = '0; move_valid2 = 1'b0;
    mx = 5; my = 5;
    test_reset();
    test_floor_left();
    test_bounds();
    test_wall();
    test_invalid();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
